// File: rtl/beams_cpri_tx_pack.sv
// CPRI TX packer: shift/quantize 16 beam sums to 16-bit I/Q, buffer two RBG blocks,
// stream each as 8 x 64-bit words with a sequence number. Macro BEAMS_CPRI_TX_SAT_EN selects saturation.
module beams_cpri_tx_pack #(
  parameter int BEAM    = 16,
  parameter int OW      = 48,
  parameter int SEQ_MAX = 96
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BEAM*OW-1:0] i_rbg_sum_re,
  input  logic [BEAM*OW-1:0] i_rbg_sum_im,
  input  logic               i_rbg_vld,
  input  logic               i_rbg_last,
  input  logic [5:0]         i_shift,
  output logic [63:0]        o_cpri_tx_data,
  output logic [6:0]         o_cpri_tx_seq,
  output logic               o_cpri_tx_vld,
  input  logic               i_cpri_tx_ready,
  output logic               o_cpri_tx_last,
  output logic               o_overflow
);
  localparam int NW  = BEAM / 2;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam int EW  = BEAM * 32;

`ifdef BEAMS_CPRI_TX_SAT_EN
  localparam logic signed [OW-1:0] Q_MAX = OW'(32767);
  localparam logic signed [OW-1:0] Q_MIN = OW'(-32768);
`endif

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  function automatic logic [15:0] quant(input logic [OW-1:0] x, input logic [5:0] sh);
    logic signed [OW-1:0] s;
    s = $signed(x) >>> sh;
`ifdef BEAMS_CPRI_TX_SAT_EN
    if (s > Q_MAX) return 16'h7fff;
    if (s < Q_MIN) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  logic           s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [EW-1:0]  s1_data_q, s1_data_d;
  logic [EW-1:0]  buf_q [2];
  logic [EW-1:0]  buf_d [2];
  logic [1:0]     blast_q, blast_d;
  logic           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]     cnt_q, cnt_d;
  state_e         state_q, state_d;
  logic [WIW-1:0] widx_q, widx_d;
  logic [63:0]    data_q, data_d;
  logic [6:0]     seq_q, seq_d;
  logic           vld_q, vld_d, last_q, last_d, ovf_q, ovf_d;

  logic           acc, pop, wr, start;
  logic [1:0]     avail;
  logic [EW-1:0]  nsrc;
  logic           nlast;

  always_comb begin
    s1_data_d = '0;
    for (int unsigned b = 0; b < BEAM; b++) begin
      s1_data_d[b*32 +: 16]    = quant(i_rbg_sum_im[b*OW +: OW], i_shift);
      s1_data_d[b*32+16 +: 16] = quant(i_rbg_sum_re[b*OW +: OW], i_shift);
    end
    s1_vld_d  = i_rbg_vld;
    s1_last_d = i_rbg_last;
  end

  always_comb begin
    buf_d    = buf_q;
    blast_d  = blast_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    widx_d   = widx_q;
    data_d   = data_q;
    seq_d    = seq_q;
    vld_d    = vld_q;
    last_d   = last_q;
    nsrc     = s1_data_q;
    nlast    = s1_last_q;

    acc   = vld_q & i_cpri_tx_ready;
    pop   = acc & (widx_q == WIW'(NW-1));
    wr    = s1_vld_q & ((cnt_q != 2'd2) | pop);
    cnt_d = cnt_q + 2'(wr) - 2'(pop);
    avail = cnt_q - 2'(pop);
    ovf_d = ovf_q | (s1_vld_q & ~wr);

    if (wr) begin
      buf_d[wr_ptr_q]   = s1_data_q;
      blast_d[wr_ptr_q] = s1_last_q;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    if (acc)
      seq_d = (last_q || seq_q == 7'(SEQ_MAX-1)) ? '0 : seq_q + 7'd1;

    // A block being written this cycle is forwarded straight from stage 1 when
    // no older entry is waiting, so word 0 appears without an extra cycle.
    start = (state_q == ST_IDLE) | pop;
    if (start) begin
      if (avail != 2'd0 || wr) begin
        if (avail != 2'd0) begin
          nsrc  = buf_q[rd_ptr_d];
          nlast = blast_q[rd_ptr_d];
        end
        state_d = ST_SEND;
        vld_d   = 1'b1;
        widx_d  = '0;
        data_d  = nsrc[63:0];
        last_d  = nlast & (NW == 1);
      end else begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        last_d  = 1'b0;
      end
    end else if (acc) begin
      widx_d = widx_q + WIW'(1);
      data_d = buf_q[rd_ptr_q][int'(widx_d)*64 +: 64];
      last_d = blast_q[rd_ptr_q] & (widx_d == WIW'(NW-1));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_data_q <= '0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      blast_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      widx_q    <= '0;
      data_q    <= '0;
      seq_q     <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_data_q <= s1_data_d;
      buf_q     <= buf_d;
      blast_q   <= blast_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      widx_q    <= widx_d;
      data_q    <= data_d;
      seq_q     <= seq_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_cpri_tx_data = data_q;
  assign o_cpri_tx_seq  = seq_q;
  assign o_cpri_tx_vld  = vld_q;
  assign o_cpri_tx_last = last_q;
  assign o_overflow     = ovf_q;
endmodule

// File: tb/tb_beams_cpri_tx_pack.sv
// Randomized bench for beams_cpri_tx_pack against a block-level reference model
// (expected-word queue, block occupancy counters, arithmetic quantizer).
module tb_beams_cpri_tx_pack;
  localparam int BEAM = 16, OW = 48, NW = 8, SEQ_MAX = 96;

  logic               clk = 1'b0;
  logic               rst;
  logic [BEAM*OW-1:0] sum_re, sum_im;
  logic               rbg_vld, rbg_last;
  logic [5:0]         shift;
  logic [63:0]        tx_data;
  logic [6:0]         tx_seq;
  logic               tx_vld, tx_ready, tx_last, ovf;

  always #5 clk = ~clk;

  beams_cpri_tx_pack #(.BEAM(BEAM), .OW(OW), .SEQ_MAX(SEQ_MAX)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rbg_sum_re(sum_re), .i_rbg_sum_im(sum_im),
    .i_rbg_vld(rbg_vld), .i_rbg_last(rbg_last), .i_shift(shift),
    .o_cpri_tx_data(tx_data), .o_cpri_tx_seq(tx_seq), .o_cpri_tx_vld(tx_vld),
    .i_cpri_tx_ready(tx_ready), .o_cpri_tx_last(tx_last), .o_overflow(ovf)
  );

  typedef struct { logic [63:0] d; bit last; bit eoe; } word_t;
  word_t       exp_q[$];
  longint      re_a[BEAM], im_a[BEAM];
  int          shift_v;
  logic [63:0] pend_w[NW];
  bit          pend_vld, pend_last;
  int          written, completed, seq_m, acc_words, last_words;
  bit          ovf_m;
  bit          prev_vld, prev_acc;
  logic [63:0] prev_data;
  logic [6:0]  prev_seq;
  logic        prev_last;
  bit          cap_en, cap_done;
  logic [63:0] cap_word;
  int          n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // floor(x / 2^sh), then saturate or wrap to 16 bits
  function automatic logic [15:0] mq(input longint x, input int sh);
    longint p, f;
    p = longint'(1) << sh;
    if (x >= 0) f = x / p;
    else        f = -((-x + p - 1) / p);
`ifdef BEAMS_CPRI_TX_SAT_EN
    if (f > 32767)  return 16'h7fff;
    if (f < -32768) return 16'h8000;
`endif
    return f[15:0];
  endfunction

  task automatic apply_inputs();
    for (int b = 0; b < BEAM; b++) begin
      sum_re[b*OW +: OW] = re_a[b][OW-1:0];
      sum_im[b*OW +: OW] = im_a[b][OW-1:0];
    end
    shift = 6'(shift_v);
  endtask

  function automatic longint rand48();
    longint v;
    v = {$urandom, $urandom};
    v = (v <<< 16) >>> 16;
    return v >>> $urandom_range(0, 32);
  endfunction

  task automatic randomize_block();
    for (int b = 0; b < BEAM; b++) begin
      re_a[b] = rand48();
      im_a[b] = rand48();
    end
    shift_v = $urandom_range(0, 32);
  endtask

  task automatic model_clear();
    exp_q.delete();
    written = 0; completed = 0; seq_m = 0; ovf_m = 0;
    pend_vld = 0; prev_vld = 0; prev_acc = 0;
  endtask

  // One clock cycle: check outputs of the current cycle, advance the model, clock.
  task automatic step();
    bit    acc;
    word_t w;
    check("overflow", ovf, ovf_m);
    if (prev_vld && !prev_acc) begin
      check("hold_vld", tx_vld, 1'b1);
      check("hold_data", tx_data, prev_data);
      check("hold_seq", tx_seq, prev_seq);
      check("hold_last", tx_last, prev_last);
    end
    check("vld", tx_vld, exp_q.size() > 0);
    acc = tx_vld && tx_ready;
    if (acc) begin
      acc_words++;
      if (tx_last) last_words++;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("data", tx_data, w.d);
        check("seq", tx_seq, seq_m);
        check("last", tx_last, w.last);
        seq_m = w.last ? 0 : (seq_m + 1) % SEQ_MAX;
        if (w.eoe) completed++;
        if (cap_en && !cap_done) begin cap_word = tx_data; cap_done = 1; end
      end
    end
    if (pend_vld) begin
      if (written - completed < 2) begin
        for (int k = 0; k < NW; k++) begin
          w.d = pend_w[k]; w.eoe = (k == NW-1); w.last = pend_last && (k == NW-1);
          exp_q.push_back(w);
        end
        written++;
      end else ovf_m = 1;
    end
    pend_vld = rbg_vld;
    if (rbg_vld) begin
      pend_last = rbg_last;
      for (int k = 0; k < NW; k++)
        pend_w[k] = {mq(re_a[2*k+1], shift_v), mq(im_a[2*k+1], shift_v),
                     mq(re_a[2*k], shift_v), mq(im_a[2*k], shift_v)};
    end
    prev_vld = tx_vld; prev_acc = acc; prev_data = tx_data;
    prev_seq = tx_seq; prev_last = tx_last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe(input bit last);
    apply_inputs();
    rbg_vld = 1; rbg_last = last;
    step();
    rbg_vld = 0; rbg_last = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1;
    while ((exp_q.size() > 0 || pend_vld) && n < 300) begin step(); n++; end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  task automatic do_reset();
    rst = 1; rbg_vld = 0; rbg_last = 0; tx_ready = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_data", tx_data, 64'd0);
    check("rst_seq", tx_seq, 7'd0);
    check("rst_vld", tx_vld, 1'b0);
    check("rst_last", tx_last, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    model_clear();
    rst = 0;
  endtask

  initial begin
    rst = 1; rbg_vld = 0; rbg_last = 0; tx_ready = 0; shift = '0;
    sum_re = '0; sum_im = '0;
    cap_en = 0; cap_done = 0; cap_word = '0;
    acc_words = 0; last_words = 0;
    model_clear();
    do_reset();

    // ramp block, shift 0, ready high
    for (int b = 0; b < BEAM; b++) begin re_a[b] = b; im_a[b] = -b; end
    shift_v = 0;
    tx_ready = 1; cap_en = 1;
    strobe(0);
    drain();
    check("word0", cap_word, 64'h0001_ffff_0000_0000);
    cap_en = 0;

    // shift 4 with quantization boundary values
    randomize_block();
    re_a[0] = 'h100; re_a[1] = 'h7ffff0; shift_v = 4;
    strobe(0);
    drain();

    // ready toggling every cycle
    randomize_block();
    tx_ready = 0;
    strobe(0);
    for (int i = 0; i < 24; i++) begin tx_ready = ~tx_ready; step(); end
    drain();

    // three blocks with ready low: third is dropped
    do_reset();
    acc_words = 0;
    for (int i = 0; i < 3; i++) begin randomize_block(); strobe(0); idle(1); end
    idle(4);
    check("drop_ovf", ovf, 1'b1);
    drain();
    check("drop_words", 64'(acc_words), 64'd16);

    // full buffer, third write coincides with head word 7 acceptance
    do_reset();
    acc_words = 0;
    randomize_block(); strobe(0); idle(1);
    randomize_block(); strobe(0); idle(3);
    tx_ready = 1;
    idle(6);
    randomize_block(); strobe(0);
    drain();
    check("coinc_ovf", ovf, 1'b0);
    check("coinc_words", 64'(acc_words), 64'd24);

    // 12 blocks ending a symbol, then one more block
    do_reset();
    tx_ready = 1; last_words = 0;
    for (int i = 0; i < 13; i++) begin
      randomize_block(); strobe(i == 11); idle(7);
    end
    drain();
    check("last_count", 64'(last_words), 64'd1);

    // reset in the middle of a block
    randomize_block(); strobe(0); idle(5);
    do_reset();
    step();
    randomize_block(); strobe(1);
    drain();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        randomize_block(); strobe($urandom_range(0, 3) == 0);
      end else step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/beams_cpri_tx_pack.md
# beams_cpri_tx_pack

Transmit-side packer for the beam-reduced uplink path. It takes the per-RBG beam sums (16 beams, 48-bit I/Q) produced by the dimension-reduction datapath, then scales and quantizes each to 16-bit I/Q. It buffers up to two RBG blocks and serializes each block onto the 64-bit CPRI TX word stream with a 7-bit sequence number, using a valid/ready handshake. It is the egress counterpart of the CPRI RX unpack/buffer chain.

## Interface
- BEAM, 16, beams per RBG block (fixed, even)
- OW, 48, input I/Q width per component
- SEQ_MAX, 96, sequence wrap value (seq counts 0..SEQ_MAX-1)
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_rbg_sum_re  in  BEAM*OW  per-beam real sums, beam b at [b*OW +: OW], signed
- i_rbg_sum_im  in  BEAM*OW  per-beam imag sums, same layout
- i_rbg_vld  in  1  one-cycle strobe: sums valid
- i_rbg_last  in  1  qualifies i_rbg_vld: block is last RBG of the symbol
- i_shift  in  6  arithmetic right shift applied before quantization, sampled with i_rbg_vld, range 0..32
- o_cpri_tx_data  out  64  packed word
- o_cpri_tx_seq  out  7  word sequence number
- o_cpri_tx_vld  out  1  word valid
- i_cpri_tx_ready  in  1  downstream accepts word when vld & ready
- o_cpri_tx_last  out  1  final word of the symbol
- o_overflow  out  1  sticky: a block was dropped

## Operation
- Stage 1, registered: each component is arithmetically shifted right by i_shift (floor). It is then reduced to 16 bits per Configuration. i_rbg_last is captured alongside.
- Buffer: 2 entries of BEAM*32 bits plus a last flag, write/read pointers, count 0..2.
- Stage-1 output is written when its valid is set and either count<2, or count==2 and the last word of the head entry is accepted in the same cycle.
- Otherwise the block is dropped, o_overflow is set to 1, and it stays 1 until reset.
- Word k (k=0..BEAM/2-1) of an entry:
  - [15:0] = Q of beam 2k, [31:16] = I of beam 2k
  - [47:32] = Q of beam 2k+1, [63:48] = I of beam 2k+1
- FSM IDLE/SEND:
  - IDLE→SEND when count>0. The output register is loaded with word 0 of the head entry.
  - In SEND, on acceptance of word k<7, load word k+1.
  - On acceptance of word 7, free the entry. Go to SEND with the next entry's word 0 if count (after update) >0, else go to IDLE.
- o_cpri_tx_last = 1 only on word 7 of an entry whose last flag is set.
- Sequence:
  - Increments on each accepted word and wraps SEQ_MAX-1→0.
  - Forced back to 0 after an accepted word with o_cpri_tx_last=1.
  - The presented word carries the current count.

## Timing
- Reset values: o_cpri_tx_data=0, o_cpri_tx_seq=0, o_cpri_tx_vld=0, o_cpri_tx_last=0, o_overflow=0. FSM in IDLE, count=0, pointers=0.
- Reset mid-block discards both buffer entries and any partial word stream. No output vld on the cycle after deassertion.
- Latency: i_rbg_vld at cycle N → stage-1 valid at N+1 → first o_cpri_tx_vld at N+2 (buffer empty, FSM idle).
- With ready held high, the 8 words of an entry are on consecutive cycles. A queued second entry follows with no gap.
- While vld=1 and ready=0, data, seq and last are held stable. vld never drops without acceptance.
- i_rbg_vld on consecutive cycles is legal. Each strobe is a distinct block subject to the drop rule.
- All outputs are registered. There is no combinational path from i_cpri_tx_ready to any output.

## Configuration
- BEAMS_CPRI_TX_SAT_EN:
  - Defined: the shifted value is saturated to [-32768, 32767].
  - Undefined: the low 16 bits are kept (two's-complement wrap).
- All other behaviour is identical in both cases.

## Test plan
- Single block, shift 0, beam b I=b, Q=-b, ready=1 → 8 words from cycle N+2.
  - Word 0 = 0x0001_FFFF_0000_0000, seq 0..7.
  - last=0.
- Shift 4, beam 0 I=0x100 → I field 0x0010.
  - I=0x7FFFF0 with SAT_EN → 0x7FFF.
  - Same I without SAT_EN → 0xFFFF.
- Ready toggled 1/0 each cycle through a block → each word is held until accepted, all 8 words in order, seq contiguous.
- Ready=0, three strobes two cycles apart → the third block is dropped and o_overflow=1.
  - After ready=1, exactly 16 words are sent, from the first two blocks.
- Count==2, third strobe timed so its stage-1 write coincides with acceptance of head word 7 → no drop, o_overflow stays 0, 24 words are sent.
- 12 blocks, last on block 12 → seq wraps 95→0 at word 96. o_cpri_tx_last=1 on word 96 only, next word seq=0.
